render_sequencer: RTL and testbench

Per-frame render controller for the first-person view pipeline. Each frame it sweeps the screen with ceiling/floor background writes, then pulses start to the FPV ray-drawing stage and forwards that stage's pixel writes to the VGA adapter until it reports done. It owns the only VGA write port, so it sits directly upstream of the FPV drawer and between that drawer and the adapter.

---
 rtl/render_sequencer_pkg.sv | 22 ++
 rtl/render_sequencer_frame_tick_gen.sv | 23 ++
 rtl/render_sequencer.sv | 141 ++++++++++++++
 tb/tb_render_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/render_sequencer_pkg.sv
// Shared types and constants for the per-frame render sequencer.
package render_sequencer_pkg;

   localparam int VGA_X_W  = 8;
   localparam int VGA_Y_W  = 7;
   localparam int COLOUR_W = 18;

   localparam logic [COLOUR_W-1:0] DEFAULT_CEIL_COLOUR  = 18'h0A28A;
   localparam logic [COLOUR_W-1:0] DEFAULT_FLOOR_COLOUR = 18'h14514;

   typedef logic [VGA_X_W-1:0] vga_x_t;
   typedef logic [VGA_Y_W-1:0] vga_y_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      START,
      DRAW,
      WAIT_TICK
   } state_t;

endpackage

// File: rtl/render_sequencer_frame_tick_gen.sv
// Free-running frame-period counter; tick is high in the last cycle of each period.
module render_sequencer_frame_tick_gen #(
   parameter int FRAME_CYCLES = 833334
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)             count <= '0;
      else if (count == LAST) count <= '0;
      else                    count <= count + CNT_W'(1);
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/render_sequencer.sv
// Per-frame render controller: background sweep, FPV start, FPV write forwarding.
// RENDER_FRAME_LIMIT_EN paces frames to the frame tick; undefined renders back-to-back.
module render_sequencer
   import render_sequencer_pkg::*;
#(
   parameter int                  SCREEN_W     = 160,
   parameter int                  SCREEN_H     = 120,
   parameter int                  FRAME_CYCLES = 833334,
   parameter logic [COLOUR_W-1:0] CEIL_COLOUR  = DEFAULT_CEIL_COLOUR,
   parameter logic [COLOUR_W-1:0] FLOOR_COLOUR = DEFAULT_FLOOR_COLOUR
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   output logic                fpv_start,
   input  logic                fpv_done,
   input  logic [VGA_X_W-1:0]  fpv_x,
   input  logic [VGA_Y_W-1:0]  fpv_y,
   input  logic [COLOUR_W-1:0] fpv_colour,
   input  logic                fpv_write,
   output logic [VGA_X_W-1:0]  vga_x,
   output logic [VGA_Y_W-1:0]  vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_write,
   output logic                frame_done,
   output logic                busy
);

   if (SCREEN_W < 1 || SCREEN_W > 256 || SCREEN_H < 2 || SCREEN_H > 128 || FRAME_CYCLES < 2)
   begin : g_param_check
      $error("render_sequencer: parameter out of range");
   end

   localparam vga_x_t X_LAST = vga_x_t'(SCREEN_W - 1);
   localparam vga_y_t Y_LAST = vga_y_t'(SCREEN_H - 1);
   localparam vga_y_t Y_HALF = vga_y_t'(SCREEN_H / 2);

   state_t state;
   vga_x_t clr_x;
   vga_y_t clr_y;
   logic   frame_ready;

`ifdef RENDER_FRAME_LIMIT_EN
   logic tick;
   logic tick_pending;
   logic enter_clear;

   render_sequencer_frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_tick_gen (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   assign frame_ready = tick_pending | tick;
   assign enter_clear = enable & ((state == IDLE) | ((state == WAIT_TICK) & frame_ready));

   // Any number of ticks missed during a long frame collapse into one pending start.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)           tick_pending <= 1'b0;
      else if (enter_clear) tick_pending <= 1'b0;
      else if (tick)        tick_pending <= 1'b1;
   end
`else
   assign frame_ready = 1'b1;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         clr_x      <= '0;
         clr_y      <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_write  <= 1'b0;
         fpv_start  <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // NOTE: one-cycle strobes default low here; a later assignment in the case wins.
         vga_write  <= 1'b0;
         fpv_start  <= 1'b0;
         frame_done <= 1'b0;

         unique case (state)
            IDLE: begin
               if (enable) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               vga_x      <= clr_x;
               vga_y      <= clr_y;
               vga_colour <= (clr_y < Y_HALF) ? CEIL_COLOUR : FLOOR_COLOUR;
               vga_write  <= 1'b1;
               if (clr_x == X_LAST) begin
                  clr_x <= '0;
                  if (clr_y == Y_LAST) begin
                     clr_y <= '0;
                     state <= START;
                  end else begin
                     clr_y <= clr_y + vga_y_t'(1);
                  end
               end else begin
                  clr_x <= clr_x + vga_x_t'(1);
               end
            end
            START: begin
               fpv_start <= 1'b1;
               state     <= DRAW;
            end
            DRAW: begin
               vga_x      <= fpv_x;
               vga_y      <= fpv_y;
               vga_colour <= fpv_colour;
               vga_write  <= fpv_write;
               if (fpv_done) begin
                  frame_done <= 1'b1;
                  state      <= WAIT_TICK;
               end
            end
            WAIT_TICK: begin
               if (frame_ready) begin
                  if (enable) begin
                     state <= CLEAR;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_render_sequencer.sv
// Self-checking bench for render_sequencer: randomized FPV traffic against a frame-schedule model.
module tb_render_sequencer;

   localparam int          W     = 4;
   localparam int          H     = 2;
   localparam int          FC    = 64;
   localparam logic [17:0] CEIL  = 18'h0A28A;
   localparam logic [17:0] FLOOR = 18'h14514;

   logic        clock      = 1'b0;
   logic        reset      = 1'b0;
   logic        enable     = 1'b0;
   logic        fpv_done   = 1'b0;
   logic        fpv_write  = 1'b0;
   logic [7:0]  fpv_x      = '0;
   logic [6:0]  fpv_y      = '0;
   logic [17:0] fpv_colour = '0;
   logic        fpv_start;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [17:0] vga_colour;
   logic        vga_write;
   logic        frame_done;
   logic        busy;

   int tests  = 0;
   int failed = 0;
   int edge_n = 0;

   logic [7:0]  last_x;
   logic [6:0]  last_y;
   logic [17:0] last_col;

   always #5 clock = ~clock;

   render_sequencer #(
      .SCREEN_W     (W),
      .SCREEN_H     (H),
      .FRAME_CYCLES (FC)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .fpv_start  (fpv_start),
      .fpv_done   (fpv_done),
      .fpv_x      (fpv_x),
      .fpv_y      (fpv_y),
      .fpv_colour (fpv_colour),
      .fpv_write  (fpv_write),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_write  (vga_write),
      .frame_done (frame_done),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic step();
      @(posedge clock);
      edge_n++;
      #1;
   endtask

   // Edge at which the sequencer re-enters CLEAR (or IDLE) after fpv_done is sampled
   // at edge d, for a frame whose CLEAR was entered at edge c. Ticks land on edges k*FC.
   function automatic int next_clear(input int c, input int d);
`ifdef RENDER_FRAME_LIMIT_EN
      int t;
      t = (c / FC + 1) * FC;
      return (d + 1 > t) ? d + 1 : t;
`else
      return d + 1;
`endif
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_vga_x"},      vga_x, 0);
      check({tag, "_vga_y"},      vga_y, 0);
      check({tag, "_vga_colour"}, vga_colour, 0);
      check({tag, "_vga_write"},  vga_write, 0);
      check({tag, "_fpv_start"},  fpv_start, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_busy"},       busy, 0);
   endtask

   // Called just after the edge that entered CLEAR (edge c); returns the next entry edge.
   task automatic run_frame(input int c, input int delay, input bit drop_enable, output int c_next);
      int d;
      for (int i = 0; i < W * H; i++) begin
         step();
         check("clr_write", vga_write, 1);
         check("clr_x", vga_x, i % W);
         check("clr_y", vga_y, i / W);
         check("clr_colour", vga_colour, ((i / W) < (H / 2)) ? CEIL : FLOOR);
         check("clr_no_start", fpv_start, 0);
      end
      step();
      check("start_pulse", fpv_start, 1);
      check("start_no_write", vga_write, 0);

      for (int k = 1; k <= delay; k++) begin
         if (k == 1) begin
            fpv_x = 8'd2; fpv_y = 7'd1; fpv_colour = 18'h3FFFF; fpv_write = 1'b1;
         end else begin
            fpv_x      = 8'($urandom);
            fpv_y      = 7'($urandom);
            fpv_colour = 18'($urandom);
            fpv_write  = 1'($urandom_range(0, 1));
         end
         if (k == delay) fpv_write = 1'b1;
         fpv_done = (k == delay);
         if (drop_enable && k == delay / 2 + 1) enable = 1'b0;
         last_x = fpv_x; last_y = fpv_y; last_col = fpv_colour;
         step();
         check("draw_x", vga_x, last_x);
         check("draw_y", vga_y, last_y);
         check("draw_colour", vga_colour, last_col);
         check("draw_write", vga_write, fpv_write);
         check("draw_frame_done", frame_done, k == delay);
         check("draw_no_start", fpv_start, 0);
         check("draw_busy", busy, 1);
      end
      d = edge_n;
      fpv_done = 1'b0;
      c_next = next_clear(c, d);

      while (edge_n < c_next) begin
         fpv_x = 8'($urandom); fpv_y = 7'($urandom); fpv_colour = 18'($urandom); fpv_write = 1'b1;
         step();
         check("wait_write", vga_write, 0);
         check("wait_frame_done", frame_done, 0);
         check("wait_hold_x", vga_x, last_x);
         check("wait_hold_y", vga_y, last_y);
         check("wait_hold_colour", vga_colour, last_col);
         check("wait_no_start", fpv_start, 0);
         check("wait_busy", busy, (edge_n < c_next) ? 1'b1 : enable);
      end
      fpv_write = 1'b0;
   endtask

   initial begin
      int c;

      #12;
      check_all_zero("reset");

      @(posedge clock);
      #1;
      reset  = 1'b1;
      edge_n = 0;

      repeat (3) begin
         step();
         check("idle_busy", busy, 0);
         check("idle_write", vga_write, 0);
      end

      // fpv_done held high through CLEAR and START must not end the frame
      enable   = 1'b1;
      fpv_done = 1'b1;
      step();
      c = edge_n;
      check("enter_busy", busy, 1);
      check("enter_write", vga_write, 0);

      run_frame(c, 20, 1'b0, c);
      run_frame(c, 100, 1'b0, c);
      repeat (3) run_frame(c, int'($urandom_range(1, 90)), 1'b0, c);

      // enable dropped mid-DRAW: frame completes, then IDLE
      run_frame(c, 30, 1'b1, c);
      repeat (5) begin
         step();
         check("post_idle_busy", busy, 0);
         check("post_idle_write", vga_write, 0);
         check("post_idle_start", fpv_start, 0);
      end

      // asynchronous reset in the middle of the background sweep
      enable = 1'b1;
      step();
      repeat (3) step();
      check("pre_reset_write", vga_write, 1);
      check("pre_reset_x", vga_x, 2);
      #2 reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      step();
      step();
      reset  = 1'b0;
      check_all_zero("held_reset");
      reset  = 1'b1;
      edge_n = 0;
      step();
      c = edge_n;
      check("restart_busy", busy, 1);
      run_frame(c, 15, 1'b0, c);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
